// File: rtl/vx_alu_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vx_alu_wb_sched_pkg
// Brief   : Shared ALU PE latencies and writeback slot type.
// Revision: 1.0 - initial release
// ============================================================================
package vx_alu_wb_sched_pkg;

    localparam int ALU_INT_LAT  = 1;
    localparam int ALU_MDV_LAT  = 4;
    localparam int ALU_DOT8_LAT = 2;

    localparam int WB_PE_W  = 2;
    localparam int WB_TAG_W = 8;

    typedef struct packed {
        logic                valid;
        logic [WB_PE_W-1:0]  pe;
        logic [WB_TAG_W-1:0] tag;
    } wb_slot_t;

    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_alu_wb_sched_resv_table.sv
`default_nettype none
// ============================================================================
// Module  : vx_alu_wb_sched_resv_table
// Brief   : Shift-down reservation table; slot k = result due k cycles ahead.
// Revision: 1.0 - initial release
// ============================================================================
module vx_alu_wb_sched_resv_table #(
    parameter int DEPTH = 8,
    parameter int PE_W  = 2,
    parameter int TAG_W = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] probe_idx,
    output logic             probe_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PE_W-1:0]  wr_pe,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             head_valid,
    output logic [PE_W-1:0]  head_pe,
    output logic [TAG_W-1:0] head_tag
);

    typedef struct packed {
        logic             valid;
        logic [PE_W-1:0]  pe;
        logic [TAG_W-1:0] tag;
    } slot_t;

    slot_t r_slot  [0:DEPTH];
    slot_t w_shift [0:DEPTH];
    slot_t w_wr_data;

    assign w_wr_data = {1'b1, wr_pe, wr_tag};

    generate
        for (genvar k = 0; k <= DEPTH; k++) begin : g_shift
            if (k < DEPTH) begin : g_link
                assign w_shift[k] = r_slot[k+1];
            end else begin : g_end
                assign w_shift[k] = '0;
            end
        end
    endgenerate

    // The write lands in the post-shift image, so it wins over the shifted entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k <= DEPTH; k++) begin
                if (wr_en && (wr_idx == IDX_W'(k))) begin
                    r_slot[k] <= w_wr_data;
                end else begin
                    r_slot[k] <= w_shift[k];
                end
            end
        end
    end

    always_comb begin
        probe_valid = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            if (probe_idx == IDX_W'(k)) begin
                probe_valid = r_slot[k].valid;
            end
        end
    end

    assign head_valid = r_slot[0].valid;
    assign head_pe    = r_slot[0].pe;
    assign head_tag   = r_slot[0].tag;

endmodule
`default_nettype wire

// File: rtl/vx_alu_wb_sched.sv
`default_nettype none
// ============================================================================
// Module  : vx_alu_wb_sched
// Brief   : Issue scheduler reserving the shared writeback slot at issue time.
// Revision: 1.0 - initial release
// ============================================================================
module vx_alu_wb_sched
    import vx_alu_wb_sched_pkg::*;
#(
    parameter int PE_COUNT = 3,
    parameter int MAX_LAT  = 8,
    parameter logic [PE_COUNT*$clog2(MAX_LAT+1)-1:0] PE_LATENCY =
        {4'(ALU_DOT8_LAT), 4'(ALU_MDV_LAT), 4'(ALU_INT_LAT)},
    parameter int TAG_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [up_clog2(PE_COUNT)-1:0] in_pe_sel,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          in_ready,
    output logic [PE_COUNT-1:0]           pe_valid,
    input  logic [PE_COUNT-1:0]           pe_ready,
    output logic                          wb_valid,
    output logic [up_clog2(PE_COUNT)-1:0] wb_pe,
    output logic [TAG_WIDTH-1:0]          wb_tag,
    output logic [31:0]                   perf_stalls
);

    localparam int c_lat_w = $clog2(MAX_LAT + 1);
    localparam int c_sel_w = up_clog2(PE_COUNT);

    generate
        if (PE_COUNT < 1) begin : g_bad_count
            $error("vx_alu_wb_sched: PE_COUNT must be at least 1");
        end
        for (genvar p = 0; p < PE_COUNT; p++) begin : g_lat_chk
            if ((int'(PE_LATENCY[p*c_lat_w +: c_lat_w]) < 1) ||
                (int'(PE_LATENCY[p*c_lat_w +: c_lat_w]) > MAX_LAT)) begin : g_bad_lat
                $error("vx_alu_wb_sched: PE latency out of range 1..MAX_LAT");
            end
        end
    endgenerate

    logic [c_lat_w-1:0] w_lat;
    logic               w_sel_ok;
    logic               w_sel_ready;
    logic               w_probe_valid;
    logic               w_conflict;
    logic               w_fire;
    logic [31:0]        r_perf_stalls;

    // An out-of-range select matches no PE: zero latency, not ready.
    always_comb begin
        w_lat       = '0;
        w_sel_ok    = 1'b0;
        w_sel_ready = 1'b0;
        for (int p = 0; p < PE_COUNT; p++) begin
            if (in_pe_sel == c_sel_w'(p)) begin
                w_sel_ok    = 1'b1;
                w_lat       = PE_LATENCY[p*c_lat_w +: c_lat_w];
                w_sel_ready = pe_ready[p];
            end
        end
    end

    assign w_conflict = w_sel_ok && w_probe_valid;
    assign in_ready   = w_sel_ready && !w_conflict;
    assign w_fire     = in_valid && in_ready;

    generate
        for (genvar p = 0; p < PE_COUNT; p++) begin : g_pe_valid
            assign pe_valid[p] = in_valid && (in_pe_sel == c_sel_w'(p)) && !w_conflict;
        end
    endgenerate

    // Probe slot L before the shift; write slot L-1 after it: same future cycle.
    vx_alu_wb_sched_resv_table #(
        .DEPTH (MAX_LAT),
        .PE_W  (c_sel_w),
        .TAG_W (TAG_WIDTH),
        .IDX_W (c_lat_w)
    ) u_resv_table (
        .clk         (clk),
        .reset       (reset),
        .probe_idx   (w_lat),
        .probe_valid (w_probe_valid),
        .wr_en       (w_fire),
        .wr_idx      (w_lat - c_lat_w'(1)),
        .wr_pe       (in_pe_sel),
        .wr_tag      (in_tag),
        .head_valid  (wb_valid),
        .head_pe     (wb_pe),
        .head_tag    (wb_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
        end else if (in_valid && w_conflict && w_sel_ready) begin
            r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_stalls = r_perf_stalls;

    a_sel_range: assert property (@(posedge clk) disable iff (reset) in_valid |-> w_sel_ok)
        else $error("vx_alu_wb_sched: in_pe_sel %0d has no PE", in_pe_sel);

endmodule
`default_nettype wire

// File: doc/vx_alu_wb_sched.md
Name: VX_alu_wb_sched

Overview:
- Issue scheduler placed between an ALU block's execute stream and its fixed-latency processing elements (int, muldiv, dot8).
- Reserves the shared result/writeback slot at issue time, so PE results never collide and need no result-side arbitration or buffering.
- Emits a registered writeback descriptor (valid, PE index, tag) the cycle each result is due. The block's result mux uses it to select the PE output.

Parameters:
- PE_COUNT, 3, number of processing elements behind the block.
- MAX_LAT, 8, largest supported PE latency in cycles.
- PE_LATENCY, {2,4,1} (PE2..PE0 packed, `CLOG2(MAX_LAT+1) bits each), fixed issue-to-result latency per PE.
- TAG_WIDTH, 8, width of the opaque tag carried to writeback.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_pe_sel  in  `UP(`CLOG2(PE_COUNT))  target PE index
- in_tag  in  TAG_WIDTH  request tag
- in_ready  out  1  request accepted this cycle
- pe_valid  out  PE_COUNT  one-hot issue valid per PE
- pe_ready  in  PE_COUNT  per-PE ready
- wb_valid  out  1  a result is due this cycle
- wb_pe  out  `UP(`CLOG2(PE_COUNT))  PE producing the due result
- wb_tag  out  TAG_WIDTH  tag of the due result
- perf_stalls  out  32  count of cycles lost to slot conflicts

Behaviour:
- Reservation table: slots 0..MAX_LAT, each holding {valid, pe, tag}. Slot k means "result due k cycles from now". Slot 0 drives wb_valid/wb_pe/wb_tag directly from flops.
- Every cycle the table shifts down by one (slot k+1 -> slot k). Slot MAX_LAT refills with invalid unless it is written.
- L = PE_LATENCY[in_pe_sel]. conflict = slot[L].valid, checked on the pre-shift view.
- pe_valid[p] = in_valid && in_pe_sel==p && !conflict. It must not depend on pe_ready.
- in_ready = pe_ready[in_pe_sel] && !conflict.
- fire = in_valid && in_ready. On fire, slot L-1 of the next state gets {1, sel, tag}, written in the same cycle as the shift.
- Latency: a request firing at cycle t appears at wb_valid at cycle t+L exactly.
- No writeback backpressure; PEs are fixed-latency pipelines.
- At most one issue per cycle, so at most one table write per cycle. No write/write collision is possible.
- The shift write into slot L-1 and the conflict check on slot L refer to the same physical future cycle. A back-to-back issue to the same PE never conflicts.
- Stall accounting: perf_stalls increments when in_valid && conflict && pe_ready[in_pe_sel]. It wraps at 2^32.
- in_pe_sel >= PE_COUNT: treated as no PE. pe_valid=0, in_ready=0, simulation assertion fires.
- Elaboration-time checks: every PE_LATENCY entry in 1..MAX_LAT; PE_COUNT >= 1.
- Reset, including mid-operation: all slot valids cleared, perf_stalls=0. Outputs are wb_valid=0, wb_pe=0, wb_tag=0. Combinational outputs follow the cleared state (in_ready depends only on pe_ready). In-flight PE results after reset are dropped by the consumer.
- in_valid=0: table keeps shifting; no writes.

Decomposition:
- Shared package (VX_gpu_pkg): a wb_slot_t struct {valid, pe, tag} and the default PE latency localparams (ALU_INT_LAT, ALU_MDV_LAT, ALU_DOT8_LAT), so the PEs and the scheduler share one source.
- Natural sub-module: VX_wb_resv_table, the parameterized shift table with a single write port at a variable depth and a read-before-shift probe.
- The top then holds the select decode, handshake logic and perf counter.

Test Plan:
All scenarios use latencies PE0=1, PE1=4, PE2=2.
- Single issue: PE1 tag 0x11 fires at t0 -> wb_valid=1, wb_pe=1, wb_tag=0x11 at t4 only.
- Conflict: PE1 fires at t0; PE2 requested at t2 -> in_ready=0 and perf_stalls=1 at t2. PE2 fires at t3; wb PE1 at t4, PE2 at t5.
- Streaming: PE0 every cycle t0..t9, tags 0..9 -> wb_valid continuous t1..t10, tags in order, zero stalls.
- PE backpressure: pe_ready[2]=0 for 3 cycles with PE2 requested -> no fire, perf_stalls unchanged. Fires on the first ready cycle; wb 2 cycles later.
- Mixed collision: PE1 at t0 (due t4), PE0 at t3 -> conflict, stall. Retry at t4 fires, wb at t5.
- Reset mid-flight: PE1 fires at t0, reset at t2 -> no wb_valid at t4, table empty, perf_stalls=0. A fresh issue after reset behaves normally.
